// File: rtl/samp_pkg.sv
// Shared definitions for the sample capture path: state encoding and default widths.
package samp_pkg;

  localparam int unsigned DefDataWidth = 128;
  localparam int unsigned DefLenWidth  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StSkip,
    StCapture,
    StDone
  } state_e;

endpackage

// File: rtl/edge_det_rise.sv
// Rising-edge detector: the previous level is registered, the pulse is combinational.
module edge_det_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/samp_capture_ctrl.sv
// Batched capture sequencer: optional trigger wait, skip, then forwards a fixed number of
// stream beats to the sample buffer with one registered cycle of latency.
module samp_capture_ctrl
  import samp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned LEN_WIDTH  = DefLenWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [LEN_WIDTH-1:0]  cfg_skip,
  input  logic                  cfg_trig_en,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_in,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  busy,
  output logic                  done,
  output logic                  gap_err,
  output logic [LEN_WIDTH-1:0]  beat_cnt
);

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   skip_q, skip_d;
  logic                   trig_en_q, trig_en_d;
  logic [LEN_WIDTH-1:0]   skip_cnt_q, skip_cnt_d;
  logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic                   done_q, done_d;
  logic                   gap_err_q, gap_err_d;
  logic                   m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]  m_data_q;
  logic                   beat;
  logic                   trig_rise;

  assign beat = s_axis_tvalid & s_axis_tready;

  edge_det_rise u_trig_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (trig_in),
    .rise (trig_rise)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    skip_d     = skip_q;
    trig_en_d  = trig_en_q;
    skip_cnt_d = skip_cnt_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = done_q;
    gap_err_d  = gap_err_q;
    m_valid_d  = 1'b0;

    // abort overrides everything, including a coincident arm
    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            len_d      = cfg_len;
            skip_d     = cfg_skip;
            trig_en_d  = cfg_trig_en;
            skip_cnt_d = '0;
            beat_cnt_d = '0;
            gap_err_d  = 1'b0;
            done_d     = (cfg_len == '0);
            state_d    = (cfg_len == '0) ? StDone : StArmed;
          end
        end
        StArmed: begin
          if (!trig_en_q || trig_rise) state_d = (skip_q != '0) ? StSkip : StCapture;
        end
        StSkip: begin
          if (beat) begin
            skip_cnt_d = skip_cnt_q + LEN_WIDTH'(1);
            if (skip_cnt_d == skip_q) state_d = StCapture;
          end
        end
        StCapture: begin
          if (beat) begin
            m_valid_d  = 1'b1;
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
            if (beat_cnt_d == len_q) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end else begin
            gap_err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      skip_q     <= '0;
      trig_en_q  <= 1'b0;
      skip_cnt_q <= '0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
      gap_err_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      skip_q     <= skip_d;
      trig_en_q  <= trig_en_d;
      skip_cnt_q <= skip_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
      gap_err_q  <= gap_err_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= s_axis_tdata;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign busy          = (state_q == StArmed) || (state_q == StSkip) || (state_q == StCapture);
  assign done          = done_q;
  assign gap_err       = gap_err_q;
  assign beat_cnt      = beat_cnt_q;

endmodule

// File: tb/tb_samp_capture_ctrl.sv
// Directed bench for samp_capture_ctrl; tdata carries a cycle index so forwarded beats are traceable.
module tb_samp_capture_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  cfg_len;
  logic [15:0]  cfg_skip;
  logic         cfg_trig_en;
  logic         arm;
  logic         abort;
  logic         trig_in;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] s_axis_tdata;
  logic         m_axis_tvalid;
  logic [127:0] m_axis_tdata;
  logic         busy;
  logic         done;
  logic         gap_err;
  logic [15:0]  beat_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int a     = 0;
  int w0    = 0;

  int           wr_total = 0;
  logic [127:0] wr_data [0:255];
  logic         wr_done [0:255];

  samp_capture_ctrl #(
    .DATA_WIDTH (128),
    .LEN_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_len       (cfg_len),
    .cfg_skip      (cfg_skip),
    .cfg_trig_en   (cfg_trig_en),
    .arm           (arm),
    .abort         (abort),
    .trig_in       (trig_in),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .busy          (busy),
    .done          (done),
    .gap_err       (gap_err),
    .beat_cnt      (beat_cnt)
  );

  always #5 clk = ~clk;

  // Log every buffer write, with done as seen alongside it
  always @(negedge clk) begin
    if (m_axis_tvalid && wr_total < 256) begin
      wr_data[wr_total] = m_axis_tdata;
      wr_done[wr_total] = done;
      wr_total++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    s_axis_tdata = 128'(cyc);
  endtask

  task automatic do_arm(input int len, input int skip, input bit trig);
    cfg_len     = 16'(len);
    cfg_skip    = 16'(skip);
    cfg_trig_en = trig;
    arm         = 1'b1;
    a           = cyc;
    w0          = wr_total;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_len = '0; cfg_skip = '0; cfg_trig_en = 1'b0; arm = 1'b0; abort = 1'b0;
    trig_in = 1'b0; s_axis_tvalid = 1'b0; s_axis_tready = 1'b0; s_axis_tdata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    check("rst_tdata", m_axis_tdata, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_gap", 128'(gap_err), 128'd0);
    check("rst_beat_cnt", 128'(beat_cnt), 128'd0);

    // 1: len 8, no skip, no trigger, continuous stream
    s_axis_tvalid = 1'b1; s_axis_tready = 1'b1;
    do_arm(8, 0, 1'b0);
    check("t1_busy", 128'(busy), 128'd1);
    repeat (12) tick();
    check("t1_writes", 128'(wr_total - w0), 128'd8);
    check("t1_first", wr_data[w0], 128'(a + 2));
    check("t1_last", wr_data[w0 + 7], 128'(a + 9));
    check("t1_done_early", 128'(wr_done[w0 + 6]), 128'd0);
    check("t1_done_with_last", 128'(wr_done[w0 + 7]), 128'd1);
    check("t1_tvalid_after", 128'(m_axis_tvalid), 128'd0);
    check("t1_beat_cnt", 128'(beat_cnt), 128'd8);
    check("t1_busy_after", 128'(busy), 128'd0);

    // 2: trigger 20 cycles after arm, skip 3, len 4
    do_arm(4, 3, 1'b1);
    repeat (19) tick();
    check("t2_no_early_write", 128'(wr_total - w0), 128'd0);
    check("t2_busy_waiting", 128'(busy), 128'd1);
    check("t2_done_cleared", 128'(done), 128'd0);
    trig_in = 1'b1;
    repeat (12) tick();
    trig_in = 1'b0;
    check("t2_writes", 128'(wr_total - w0), 128'd4);
    check("t2_first", wr_data[w0], 128'(a + 24));
    check("t2_last", wr_data[w0 + 3], 128'(a + 27));
    check("t2_done", 128'(done), 128'd1);

    // 3: two-cycle stall after the third captured beat
    do_arm(6, 0, 1'b0);
    repeat (4) tick();
    s_axis_tvalid = 1'b0;
    tick(); tick();
    s_axis_tvalid = 1'b1;
    repeat (8) tick();
    check("t3_writes", 128'(wr_total - w0), 128'd6);
    check("t3_beat3", wr_data[w0 + 2], 128'(a + 4));
    check("t3_beat4", wr_data[w0 + 3], 128'(a + 7));
    check("t3_last", wr_data[w0 + 5], 128'(a + 9));
    check("t3_gap_err", 128'(gap_err), 128'd1);
    check("t3_done", 128'(done), 128'd1);

    // 4: abort after 3 of 10 beats, then re-arm with len 2
    do_arm(10, 0, 1'b0);
    check("t4_gap_cleared", 128'(gap_err), 128'd0);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_tvalid", 128'(m_axis_tvalid), 128'd0);
    check("t4_busy", 128'(busy), 128'd0);
    check("t4_done", 128'(done), 128'd0);
    check("t4_beat_cnt", 128'(beat_cnt), 128'd3);
    check("t4_writes", 128'(wr_total - w0), 128'd3);
    repeat (3) tick();
    check("t4_idle_stays", 128'(busy), 128'd0);
    do_arm(2, 0, 1'b0);
    repeat (6) tick();
    check("t4_rearm_writes", 128'(wr_total - w0), 128'd2);
    check("t4_rearm_done", 128'(done), 128'd1);

    // 5: zero length, then an arm pulse during a busy capture
    do_arm(0, 0, 1'b0);
    check("t5_done_now", 128'(done), 128'd1);
    check("t5_busy", 128'(busy), 128'd0);
    repeat (4) tick();
    check("t5_no_writes", 128'(wr_total - w0), 128'd0);
    do_arm(5, 0, 1'b0);
    tick(); tick();
    cfg_len = 16'd1; arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (10) tick();
    check("t5_busy_arm_writes", 128'(wr_total - w0), 128'd5);
    check("t5_busy_arm_cnt", 128'(beat_cnt), 128'd5);

    // 6: reset while armed with trigger high; re-arm needs a fresh edge
    trig_in = 1'b1;
    tick();
    do_arm(3, 0, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    check("t6_rst_busy", 128'(busy), 128'd0);
    check("t6_rst_done", 128'(done), 128'd0);
    check("t6_rst_beat_cnt", 128'(beat_cnt), 128'd0);
    check("t6_rst_tdata", m_axis_tdata, 128'd0);
    tick(); tick();
    do_arm(3, 0, 1'b1);
    repeat (10) tick();
    check("t6_level_no_fire", 128'(wr_total - w0), 128'd0);
    check("t6_still_armed", 128'(busy), 128'd1);
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    tick();
    repeat (6) tick();
    check("t6_edge_writes", 128'(wr_total - w0), 128'd3);
    check("t6_done", 128'(done), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
